// File: rtl/pipe_pkg.sv
// Shared pipeline types and helpers for the MEM->WB stage register.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR = '0;

  function automatic int unsigned pay_width(input int unsigned data_w, input int unsigned a3_w);
    return 5 * data_w + a3_w;
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-slot valid/ready register with skid entry and synchronous flush.
// in_ready is a pure state decode, so out_ready never reaches it combinationally.
module skid_buf2
  import pipe_pkg::*;
#(
  parameter int unsigned PAY_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PAY_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PAY_W-1:0] out_data
);

  state_t           r_state, w_state_nxt;
  logic [PAY_W-1:0] r_main, w_main_nxt;
  logic [PAY_W-1:0] r_skid, w_skid_nxt;
  logic             w_in_fire, w_out_fire;

  assign in_ready   = (r_state != ST_FULL);
  assign out_valid  = (r_state != ST_EMPTY);
  assign out_data   = r_main;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = '0;
      w_skid_nxt  = '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = ST_ONE;
            w_main_nxt  = in_data;
          end
        end
        ST_ONE: begin
          if (w_in_fire && !w_out_fire) begin
            w_state_nxt = ST_FULL;
            w_skid_nxt  = in_data;
          end else if (w_in_fire && w_out_fire) begin
            w_main_nxt  = in_data;
          end else if (w_out_fire) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = '0;
            w_skid_nxt  = '0;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            w_state_nxt = ST_ONE;
            w_main_nxt  = r_skid;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_main_nxt  = '0;
          w_skid_nxt  = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/wb_stage_reg.sv
// MEM->WB stage register: packs fields into skid_buf2, masks idle outputs
// to a NOP with no destination, and counts retired entries.
module wb_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned A3_W   = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_pc8,
  input  logic [DATA_W-1:0] in_d,
  input  logic [DATA_W-1:0] in_c,
  input  logic [A3_W-1:0]   in_a3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_pc8,
  output logic [DATA_W-1:0] out_d,
  output logic [DATA_W-1:0] out_c,
  output logic [A3_W-1:0]   out_a3,
  output logic [CNT_W-1:0]  retired
);

  localparam int unsigned PAY_W = pay_width(DATA_W, A3_W);

  logic [PAY_W-1:0]  w_in_pay, w_out_pay;
  logic              w_out_valid;
  logic [DATA_W-1:0] w_instr, w_pc, w_pc8, w_d, w_c;
  logic [A3_W-1:0]   w_a3;
  logic [CNT_W-1:0]  r_retired;

  assign w_in_pay = {in_instr, in_pc, in_pc8, in_d, in_c, in_a3};
  assign {w_instr, w_pc, w_pc8, w_d, w_c, w_a3} = w_out_pay;

  skid_buf2 #(.PAY_W(PAY_W)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in_pay),
    .out_valid (w_out_valid),
    .out_ready (out_ready),
    .out_data  (w_out_pay)
  );

  assign out_valid = w_out_valid;
  assign out_instr = w_out_valid ? w_instr : DATA_W'(NOP_INSTR);
  assign out_pc    = w_out_valid ? w_pc    : '0;
  assign out_pc8   = w_out_valid ? w_pc8   : '0;
  assign out_d     = w_out_valid ? w_d     : '0;
  assign out_c     = w_out_valid ? w_c     : '0;
  assign out_a3    = w_out_valid ? w_a3    : '0;
  assign retired   = r_retired;

  // Counts even in a flush cycle: WB has already sampled the outgoing entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_retired <= '0;
    else if (w_out_valid && out_ready) r_retired <= r_retired + CNT_W'(1);
  end

endmodule

// File: tb/tb_wb_stage_reg.sv
// Randomised + directed bench for wb_stage_reg against a queue-based model.
module tb_wb_stage_reg;

  typedef struct {
    logic [31:0] instr, pc, pc8, d, c;
    logic [4:0]  a3;
  } ent_t;

  logic        clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_instr = 0, in_pc = 0, in_pc8 = 0, in_d = 0, in_c = 0;
  logic [4:0]  in_a3 = 0;
  logic        in_ready, out_valid;
  logic [31:0] out_instr, out_pc, out_pc8, out_d, out_c, retired;
  logic [4:0]  out_a3;

  logic        in_ready4, out_valid4;
  logic [31:0] out_instr4, out_pc4, out_pc84, out_d4, out_c4;
  logic [4:0]  out_a34;
  logic [3:0]  retired4;

  ent_t        q[$];
  int unsigned m_retired;
  int          n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  wb_stage_reg dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_pc8(in_pc8), .in_d(in_d), .in_c(in_c), .in_a3(in_a3),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_pc8(out_pc8), .out_d(out_d), .out_c(out_c), .out_a3(out_a3), .retired(retired)
  );

  wb_stage_reg #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
    .in_instr(in_instr), .in_pc(in_pc), .in_pc8(in_pc8), .in_d(in_d), .in_c(in_c), .in_a3(in_a3),
    .out_valid(out_valid4), .out_ready(out_ready), .out_instr(out_instr4), .out_pc(out_pc4),
    .out_pc8(out_pc84), .out_d(out_d4), .out_c(out_c4), .out_a3(out_a34), .retired(retired4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every observable output with the model's view of the queue.
  task automatic check_all();
    ent_t h;
    h = '{instr: 0, pc: 0, pc8: 0, d: 0, c: 0, a3: 0};
    if (q.size() != 0) h = q[0];
    chk("out_valid", out_valid, q.size() != 0);
    chk("in_ready",  in_ready,  q.size() < 2);
    chk("out_instr", out_instr, h.instr);
    chk("out_pc",    out_pc,    h.pc);
    chk("out_pc8",   out_pc8,   h.pc8);
    chk("out_d",     out_d,     h.d);
    chk("out_c",     out_c,     h.c);
    chk("out_a3",    out_a3,    h.a3);
    chk("retired",   retired,   m_retired);
    chk("out_valid4", out_valid4, q.size() != 0);
    chk("out_instr4", out_instr4, h.instr);
    chk("retired4",  retired4,  m_retired % 16);
  endtask

  // Drive one cycle of inputs, advance model at the edge, check at the falling edge.
  task automatic cycle(input logic v, input logic [31:0] instr, input logic ordy, input logic fl);
    logic inf, outf;
    in_valid = v; in_instr = instr; out_ready = ordy; flush = fl;
    in_pc = $urandom; in_pc8 = $urandom; in_d = $urandom; in_c = $urandom;
    in_a3 = 5'($urandom);
    @(posedge clk);
    inf  = v && (q.size() < 2);
    outf = ordy && (q.size() != 0);
    if (outf) m_retired++;
    if (fl) q.delete();
    else begin
      if (outf) void'(q.pop_front());
      if (inf) q.push_back('{instr: instr, pc: in_pc, pc8: in_pc8, d: in_d, c: in_c, a3: in_a3});
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    reset = 1; in_valid = 0; flush = 0; out_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    reset = 0;
    q.delete();
    m_retired = 0;
    check_all();
  endtask

  initial begin
    int unsigned saved;
    m_retired = 0;
    @(negedge clk);
    do_reset();
    chk("reset_in_ready", in_ready, 1);
    chk("reset_retired", retired, 0);

    for (int i = 1; i <= 4; i++) begin
      cycle(1, 32'(i), 1, 0);
      chk("stream_instr", out_instr, 32'(i));
    end
    cycle(0, 0, 1, 0);
    chk("stream_retired", retired, 4);

    cycle(1, 32'hA, 0, 0);
    cycle(1, 32'hB, 0, 0);
    cycle(1, 32'hC, 0, 0);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_head", out_instr, 32'hA);
    cycle(1, 32'hC, 1, 0);
    chk("bp_second", out_instr, 32'hB);
    cycle(1, 32'hC, 1, 0);
    chk("bp_third", out_instr, 32'hC);
    cycle(0, 0, 1, 0);
    chk("bp_retired", retired, 7);

    cycle(1, 32'hA, 0, 0);
    cycle(1, 32'hB, 0, 0);
    saved = retired;
    cycle(0, 0, 0, 1);
    chk("fl_out_valid", out_valid, 0);
    chk("fl_out_a3", out_a3, 0);
    chk("fl_out_instr", out_instr, 0);
    chk("fl_in_ready", in_ready, 1);
    chk("fl_retired", retired, saved);

    cycle(1, 32'h5, 0, 0);
    saved = retired;
    cycle(1, 32'h6, 1, 1);
    chk("flc_out_valid", out_valid, 0);
    chk("flc_retired", retired, saved + 1);
    cycle(0, 0, 1, 0);
    chk("flc_dropped", out_valid, 0);

    do_reset();
    for (int i = 0; i < 17; i++) cycle(1, 32'(100 + i), 1, 0);
    cycle(0, 0, 1, 0);
    chk("wrap_retired4", retired4, 1);
    chk("wrap_retired32", retired, 17);

    cycle(1, 32'h77, 0, 0);
    cycle(1, 32'h78, 0, 0);
    #2 reset = 1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_instr", out_instr, 0);
    chk("arst_out_a3", out_a3, 0);
    chk("arst_retired", retired, 0);
    chk("arst_in_ready", in_ready, 1);
    q.delete();
    m_retired = 0;
    @(negedge clk);
    reset = 0;
    check_all();

    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 19) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/wb_stage_reg.md
# wb_stage_reg

Parametrised MEM→WB pipeline stage register with valid/ready flow control, a one-entry skid buffer, and synchronous flush. It sits between the memory stage and the register-file writeback port. It carries instruction, PC, PC+8, load data, ALU result and destination register. It supersedes the fixed-width, always-advancing W register: it adds backpressure, full throughput under stall, and a retired-instruction counter.

## Interface
- DATA_W, 32, width of instr, PC, PC+8, D and C fields
- A3_W, 5, width of destination register index
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- flush  in  1  synchronous flush (interrupt request); discards all held entries
- in_valid  in  1  MEM stage presents a valid entry
- in_ready  out  1  stage can accept an entry this cycle
- in_instr, in_pc, in_pc8, in_d, in_c  in  DATA_W each  payload fields from MEM
- in_a3  in  A3_W  destination register from MEM
- out_valid  out  1  entry presented to writeback
- out_ready  in  1  writeback consumes the entry this cycle
- out_instr, out_pc, out_pc8, out_d, out_c  out  DATA_W each  payload to WB
- out_a3  out  A3_W  destination register to WB
- retired  out  CNT_W  count of entries consumed at output

## Operation
- Payload is one packed vector, PAY_W = 5*DATA_W + A3_W. It is held in two slots: main, which drives the outputs, and skid.
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- States:
  - EMPTY: main and skid invalid.
  - ONE: main valid.
  - FULL: main and skid valid.
- out_valid = (state != EMPTY). in_ready = (state != FULL).
- in_ready depends only on registered state. There is no combinational path from out_ready to in_ready.
- Transitions when flush = 0:
  - EMPTY: in_fire → ONE, main ← in.
  - ONE, in_fire & !out_fire → FULL, skid ← in.
  - ONE, in_fire & out_fire → ONE, main ← in.
  - ONE, !in_fire & out_fire → EMPTY.
  - ONE, neither → hold.
  - FULL: out_fire → ONE, main ← skid. No input accepted because in_ready = 0.
  - FULL, !out_fire → hold.
- Any transition into EMPTY zeroes main and skid payload. Whenever out_valid = 0, all out_* fields are 0. In particular out_a3 = 0, so no writeback occurs and a NOP (instr 0) is presented.
- flush = 1 has priority over all transfers:
  - Next state is EMPTY and both slots are zeroed.
  - in_fire and out_fire in the flush cycle are discarded.
  - retired still increments if out_fire was high that cycle. WB has already sampled that entry.
- retired increments by 1 on each out_fire and wraps from 2^CNT_W−1 to 0. Only reset clears it; flush does not.
- Unused skid payload is don't-care internally but is zeroed on reset and on flush.

## Timing
- Reset values:
  - state = EMPTY, out_valid = 0, in_ready = 1.
  - All out_* payload = 0, retired = 0.
- Latency: an entry accepted at edge N is visible on out_* after edge N (one cycle).
- Throughput: one entry per cycle when out_ready is held at 1.
- Backpressure: with out_ready = 0, the stage accepts at most 2 entries. in_ready drops the cycle after the second accept.
- Order is strictly FIFO. The skid entry is never overtaken.
- Reset asserted mid-operation: outputs go to reset values asynchronously, without waiting for a clock edge. Operation restarts from EMPTY on the first edge after deassertion.
- Inputs are sampled only on the rising clk edge. Outputs are registered, except in_ready and out_valid, which are state decodes.

## Structure
- Shared package pipe_pkg holds:
  - the state enum (ST_EMPTY, ST_ONE, ST_FULL);
  - the NOP_INSTR constant (0);
  - a helper function for payload width.
- Sub-module skid_buf2 is generic over PAY_W. It contains the two slots, the state machine and the flush logic.
- wb_stage_reg only packs/unpacks the fields, zero-masks the outputs, and implements the retired counter.

## Test plan
- Reset then stream: reset high 3 cycles, then 4 entries with instr 0x1..0x4, out_ready = 1 → out_instr 0x1..0x4 on consecutive cycles, each one cycle after accept; retired = 4.
- Backpressure: out_ready = 0, offer 0xA, 0xB, 0xC → 0xA and 0xB accepted, in_ready = 0 while 0xC is held. Raise out_ready → outputs 0xA, 0xB, 0xC in order with no loss or duplication.
- Flush in FULL: fill with 0xA, 0xB, assert flush with out_ready = 0 → next cycle out_valid = 0, out_a3 = 0, out_instr = 0, in_ready = 1; retired unchanged.
- Flush coincident with out_fire and in_fire: main = 0x5, out_ready = 1, in = 0x6, flush = 1 → state EMPTY, 0x6 is dropped, retired +1.
- Counter wrap: with CNT_W = 4, retire 17 entries → retired = 1.
- Async reset mid-stream: assert reset between edges while FULL → out_valid and all outputs are 0 before the next edge; retired = 0.
